// File: rtl/pipeline_ex.sv
// pipeline_ex -- execute stage with ALU, iterative multiplier and EX/MEM register.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   exRst        asynchronous active-high reset for all state
//   exHold       downstream stall: freezes the EX/MEM register
//   exKill       squash: EX/MEM register loads a bubble
//   pc8In        return address of the instruction in this stage
//   busA, busB   register operands (busB is also the store data)
//   imm32        extended immediate
//   aluSrc       operand B select: 1 = imm32, 0 = busB
//   aluCtr       operation code
//   RwIn         destination register
//   ctlIn        {regWr, memWr, dExtOp, dSizeOp[1:0], jal, mem2reg}
//   pc8, aluOut, busBOut, RwOut, regWrOut, memWr, dExtOp, dSizeOp, jal, mem2reg
//                registered fields for the memory stage
//   exStall      combinational request for upstream to hold this instruction
//   dbg_busy     multiplier FSM state (1 = BUSY), for observation only
//
// Flow control: the stage holds one instruction. exStall asks upstream to
// keep the same instruction on the inputs next cycle, and this stage sends a
// bubble downstream meanwhile. exHold comes from downstream and freezes the
// output register; the multiplier keeps running regardless of exHold.
module pipeline_ex (
    input  logic        clk,
    input  logic        exRst,
    input  logic        exHold,
    input  logic        exKill,
    input  logic [31:0] pc8In,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic [31:0] imm32,
    input  logic        aluSrc,
    input  logic [3:0]  aluCtr,
    input  logic [4:0]  RwIn,
    input  logic [6:0]  ctlIn,
    output logic [31:0] pc8,
    output logic [31:0] aluOut,
    output logic [31:0] busBOut,
    output logic [4:0]  RwOut,
    output logic        regWrOut,
    output logic        memWr,
    output logic        dExtOp,
    output logic [1:0]  dSizeOp,
    output logic        jal,
    output logic        mem2reg,
    output logic        exStall,
    output logic        dbg_busy
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

    mul_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] hi, lo;
    logic [63:0] mcand;   // shifted-left multiplicand magnitude
    logic [31:0] mplier;  // shifted-right multiplier magnitude
    logic [63:0] acc;
    logic        neg;

    logic [31:0] opb;
    logic [4:0]  sh;
    logic        is_hilo, is_mul, is_signed, mul_start;
    logic [31:0] a_mag, b_mag;
    logic [63:0] acc_next;
    logic [31:0] alu_res;

    assign opb       = aluSrc ? imm32 : busB;
    assign sh        = busA[4:0];
    assign is_hilo   = (aluCtr[3:2] == 2'b11);
    assign is_mul    = (aluCtr[3:1] == 3'b111);
    assign is_signed = (aluCtr == 4'hE);
    assign mul_start = (state == IDLE) && is_mul && !exHold && !exKill;

    // Signed multiply works on magnitudes; 0x80000000 negates to itself,
    // which is the correct unsigned magnitude 2^31.
    assign a_mag = (is_signed && busA[31]) ? (32'd0 - busA) : busA;
    assign b_mag = (is_signed && opb[31])  ? (32'd0 - opb)  : opb;

    assign acc_next = acc + (mplier[0] ? mcand : 64'd0);

    assign exStall  = !exRst && (state == BUSY) && is_hilo;
    assign dbg_busy = (state == BUSY);

    always_comb begin
        alu_res = 32'd0;
        case (aluCtr)
            4'h0: alu_res = busA + opb;
            4'h1: alu_res = busA - opb;
            4'h2: alu_res = busA & opb;
            4'h3: alu_res = busA | opb;
            4'h4: alu_res = busA ^ opb;
            4'h5: alu_res = ~(busA | opb);
            4'h6: alu_res = {31'd0, ($signed(busA) < $signed(opb))};
            4'h7: alu_res = {31'd0, (busA < opb)};
            4'h8: alu_res = opb << sh;
            4'h9: alu_res = opb >> sh;
            4'hA: alu_res = $unsigned($signed(opb) >>> sh);
            4'hB: alu_res = {opb[15:0], 16'd0};
            4'hC: alu_res = hi;
            4'hD: alu_res = lo;
            default: alu_res = 32'd0;
        endcase
    end

    // Multiplier: one multiplier bit per BUSY edge; the edge seeing cnt==0
    // consumes the last bit and commits the (sign-corrected) product.
    always_ff @(posedge clk or posedge exRst) begin
        if (exRst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand  <= {32'd0, a_mag};
                        mplier <= b_mag;
                        acc    <= 64'd0;
                        neg    <= is_signed && (busA[31] ^ opb[31]);
                        cnt    <= 5'd31;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[62:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        {hi, lo} <= neg ? (64'd0 - acc_next) : acc_next;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EX/MEM register: reset > kill > hold > stall > load.
    always_ff @(posedge clk or posedge exRst) begin
        if (exRst) begin
            pc8 <= '0; aluOut <= '0; busBOut <= '0; RwOut <= '0;
            regWrOut <= 1'b0; memWr <= 1'b0; dExtOp <= 1'b0;
            dSizeOp <= '0; jal <= 1'b0; mem2reg <= 1'b0;
        end else if (exKill || (!exHold && exStall)) begin
            pc8 <= '0; aluOut <= '0; busBOut <= '0; RwOut <= '0;
            regWrOut <= 1'b0; memWr <= 1'b0; dExtOp <= 1'b0;
            dSizeOp <= '0; jal <= 1'b0; mem2reg <= 1'b0;
        end else if (!exHold) begin
            pc8      <= pc8In;
            aluOut   <= is_mul ? 32'd0 : alu_res;
            busBOut  <= busB;
            RwOut    <= RwIn;
            regWrOut <= ctlIn[6] && !is_mul;  // multiplies never write the register file
            memWr    <= ctlIn[5];
            dExtOp   <= ctlIn[4];
            dSizeOp  <= ctlIn[3:2];
            jal      <= ctlIn[1];
            mem2reg  <= ctlIn[0];
        end
    end

endmodule

// File: tb/tb_pipeline_ex.sv
// tb_pipeline_ex -- directed + randomized self-checking bench for pipeline_ex.
module tb_pipeline_ex;

    logic        clk = 1'b0;
    logic        exRst, exHold, exKill;
    logic [31:0] pc8In, busA, busB, imm32;
    logic        aluSrc;
    logic [3:0]  aluCtr;
    logic [4:0]  RwIn;
    logic [6:0]  ctlIn;
    logic [31:0] pc8, aluOut, busBOut;
    logic [4:0]  RwOut;
    logic        regWrOut, memWr, dExtOp, jal, mem2reg, exStall, dbg_busy;
    logic [1:0]  dSizeOp;

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_ex dut (
        .clk(clk), .exRst(exRst), .exHold(exHold), .exKill(exKill),
        .pc8In(pc8In), .busA(busA), .busB(busB), .imm32(imm32),
        .aluSrc(aluSrc), .aluCtr(aluCtr), .RwIn(RwIn), .ctlIn(ctlIn),
        .pc8(pc8), .aluOut(aluOut), .busBOut(busBOut), .RwOut(RwOut),
        .regWrOut(regWrOut), .memWr(memWr), .dExtOp(dExtOp), .dSizeOp(dSizeOp),
        .jal(jal), .mem2reg(mem2reg), .exStall(exStall), .dbg_busy(dbg_busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [74:0] out_pack;
    assign out_pack = {pc8, busBOut, RwOut, memWr, dExtOp, dSizeOp, jal, mem2reg};

    function automatic logic [74:0] in_pack();
        return {pc8In, busB, RwIn, ctlIn[5:0]};
    endfunction

    // reference model helpers
    function automatic logic [31:0] alu_ref(input logic [3:0] ctr, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
        int s;
        longint sa, sb;
        s  = int'(a[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctr)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return (sa < sb) ? 32'd1 : 32'd0;
            4'h7: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            4'h8: return 32'(longint'(b) * (longint'(1) << s));
            4'h9: return 32'(longint'(b) / (longint'(1) << s));
            4'hA: return 32'(sb >>> s);
            4'hB: return 32'(longint'(b) * 65536);
            4'hC: return h;
            4'hD: return l;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'd0, a} * {32'd0, b};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src);
        aluCtr = ctr; busA = a; busB = b; imm32 = imm; aluSrc = src;
        pc8In  = $urandom;
        RwIn   = 5'($urandom_range(0, 31));
        ctlIn  = 7'($urandom_range(0, 127));
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_load(input string tag, input logic [31:0] exp_alu, input logic exp_rw);
        chk({tag, "_alu"}, 128'(aluOut), 128'(exp_alu));
        chk({tag, "_regwr"}, 128'(regWrOut), 128'(exp_rw));
        chk({tag, "_fields"}, 128'(out_pack), 128'(in_pack()));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu"}, 128'(aluOut), 128'd0);
        chk({tag, "_regwr"}, 128'(regWrOut), 128'd0);
        chk({tag, "_fields"}, 128'(out_pack), 128'd0);
    endtask

    task automatic wait_stall(input int budget, output int cycles);
        cycles = 0;
        while (exStall === 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    // scoreboard of HI/LO as predicted by the model
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
    logic [63:0] prod;
    logic [74:0] held;
    logic [31:0] ra, rb;
    logic        rs;
    int          ncyc;

    initial begin
        exRst = 1'b1; exHold = 1'b0; exKill = 1'b0;
        drive(4'hE, 32'd5, 32'd6, 32'd0, 1'b0);
        #1;
        chk_zero("reset");
        chk("reset_stall", 128'(exStall), 128'd0);
        chk("reset_busy", 128'(dbg_busy), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        exRst = 1'b0;

        // directed ALU corner cases
        drive(4'h0, 32'h7FFFFFFF, $urandom, 32'd1, 1'b1);
        step(); chk_load("add_wrap", 32'h80000000, ctlIn[6]);
        drive(4'h6, 32'hFFFFFFFF, 32'd1, $urandom, 1'b0);
        step(); chk_load("slt", 32'd1, ctlIn[6]);
        drive(4'h7, 32'hFFFFFFFF, 32'd1, $urandom, 1'b0);
        step(); chk_load("sltu", 32'd0, ctlIn[6]);

        // randomized ALU operations
        for (int i = 0; i < 40; i++) begin
            drive(4'($urandom_range(0, 11)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            #1 chk("alu_nostall", 128'(exStall), 128'd0);
            step();
            chk_load("alu_rand", alu_ref(aluCtr, busA, aluSrc ? imm32 : busB, hi_m, lo_m), ctlIn[6]);
        end

        // MULT 7 x -3, then MFLO/MFHI
        drive(4'hE, 32'd7, 32'hFFFFFFFD, $urandom, 1'b0);
        step(); chk_load("mult_bubble", 32'd0, 1'b0);
        chk("mult_busy", 128'(dbg_busy), 128'd1);
        drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
        #1 chk("mflo_stall", 128'(exStall), 128'd1);
        step(); chk_zero("stall_bubble");
        wait_stall(100, ncyc);
        chk("mult_stall_cycles", 128'(ncyc + 1), 128'd32);
        step(); chk_load("mflo_7x-3", 32'hFFFFFFEB, ctlIn[6]);
        drive(4'hC, $urandom, $urandom, $urandom, 1'b0);
        step(); chk_load("mfhi_7x-3", 32'hFFFFFFFF, ctlIn[6]);

        // MULTU 0xFFFFFFFF x 2, MFHI right after E32
        drive(4'hF, 32'hFFFFFFFF, $urandom, 32'd2, 1'b1);
        step(); chk_load("multu_bubble", 32'd0, 1'b0);
        drive(4'h0, $urandom, $urandom, $urandom, 1'b0);
        repeat (31) step();
        chk("busy_before_e32", 128'(dbg_busy), 128'd1);
        step();
        chk("idle_after_e32", 128'(dbg_busy), 128'd0);
        drive(4'hC, $urandom, $urandom, $urandom, 1'b0);
        #1 chk("mfhi_nostall", 128'(exStall), 128'd0);
        step(); chk_load("mfhi_multu", 32'h00000001, ctlIn[6]);
        drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
        step(); chk_load("mflo_multu", 32'hFFFFFFFE, ctlIn[6]);

        // exHold during BUSY: outputs frozen, multiplier keeps going
        ra = $urandom; rb = $urandom;
        prod = mul_ref(1'b1, ra, rb);
        drive(4'hE, ra, rb, $urandom, 1'b0);
        step(); chk_load("hold_mult", 32'd0, 1'b0);
        held = in_pack();
        exHold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'h0, $urandom, $urandom, $urandom, 1'b0);
            step();
            chk("hold_alu", 128'(aluOut), 128'd0);
            chk("hold_fields", 128'(out_pack), 128'(held));
        end
        exHold = 1'b0;
        repeat (27) step();
        hi_m = prod[63:32]; lo_m = prod[31:0];
        drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
        #1 chk("hold_mflo_nostall", 128'(exStall), 128'd0);
        step(); chk_load("hold_mflo", lo_m, ctlIn[6]);
        drive(4'hC, $urandom, $urandom, $urandom, 1'b0);
        step(); chk_load("hold_mfhi", hi_m, ctlIn[6]);

        // exKill on the MULT cycle: no start, HI/LO untouched
        exKill = 1'b1;
        drive(4'hE, $urandom, $urandom, $urandom, 1'b0);
        step(); chk_zero("kill_bubble");
        chk("kill_idle", 128'(dbg_busy), 128'd0);
        exKill = 1'b0;
        drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
        #1 chk("kill_nostall", 128'(exStall), 128'd0);
        step(); chk_load("kill_mflo", lo_m, ctlIn[6]);

        // reset at BUSY cycle 10
        drive(4'hF, $urandom, $urandom, $urandom, 1'b0);
        step();
        drive(4'h0, $urandom, $urandom, $urandom, 1'b0);
        repeat (10) step();
        drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
        #1 chk("pre_rst_stall", 128'(exStall), 128'd1);
        exRst = 1'b1;
        #1;
        chk_zero("rst_busy");
        chk("rst_busy_state", 128'(dbg_busy), 128'd0);
        chk("rst_busy_stall", 128'(exStall), 128'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(posedge clk); #1;
        exRst = 1'b0;
        #1 chk("post_rst_stall", 128'(exStall), 128'd0);
        step(); chk_load("post_rst_mflo", 32'd0, ctlIn[6]);
        drive(4'hC, $urandom, $urandom, $urandom, 1'b0);
        step(); chk_load("post_rst_mfhi", 32'd0, ctlIn[6]);

        // back-to-back MULT 3x4 then 5x6
        drive(4'hE, 32'd3, 32'd4, $urandom, 1'b0);
        step(); chk_load("b2b_first", 32'd0, 1'b0);
        drive(4'hE, 32'd5, $urandom, 32'd6, 1'b1);
        #1 chk("b2b_second_stall", 128'(exStall), 128'd1);
        wait_stall(100, ncyc);
        chk("b2b_stall_cycles", 128'(ncyc), 128'd32);
        step(); chk_load("b2b_second", 32'd0, 1'b0);
        chk("b2b_second_busy", 128'(dbg_busy), 128'd1);
        drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
        wait_stall(100, ncyc);
        chk("b2b_mflo_stall_cycles", 128'(ncyc), 128'd32);
        step(); chk_load("b2b_mflo", 32'd30, ctlIn[6]);
        drive(4'hC, $urandom, $urandom, $urandom, 1'b0);
        step(); chk_load("b2b_mfhi", 32'd0, ctlIn[6]);

        // randomized signed/unsigned multiplies, plus the most-negative corner
        for (int i = 0; i < 5; i++) begin
            ra = (i == 0) ? 32'h80000000 : $urandom;
            rb = (i == 0) ? 32'h80000000 : $urandom;
            rs = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            prod = mul_ref(rs, ra, rb);
            drive(rs ? 4'hE : 4'hF, ra, rb, $urandom, 1'b0);
            step(); chk_load("rmul_bubble", 32'd0, 1'b0);
            drive(4'hD, $urandom, $urandom, $urandom, 1'b0);
            wait_stall(100, ncyc);
            chk("rmul_stall_cycles", 128'(ncyc), 128'd32);
            step(); chk_load("rmul_mflo", prod[31:0], ctlIn[6]);
            drive(4'hC, $urandom, $urandom, $urandom, 1'b0);
            step(); chk_load("rmul_mfhi", prod[63:32], ctlIn[6]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ex.md
PIPELINE_EX -- requirements
Module: pipeline_ex

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 exRst  input  1  asynchronous, active-high reset; all state, including the pipeline register, clears immediately on assertion.
REQ-003 exHold  input  1  downstream stall; freezes the output pipeline register.
REQ-004 exKill  input  1  squash; the pipeline register loads a bubble (all zeros).
REQ-005 pc8In  input  32  return address (PC+8) of the instruction in this stage.
REQ-006 busA, busB  input  32 each  register operands.
REQ-007 imm32  input  32  extended immediate.
REQ-008 aluSrc  input  1  selects operand B: 1 = imm32, 0 = busB.
REQ-009 aluCtr  input  4  operation code (REQ-015).
REQ-010 RwIn  input  5  destination register.
REQ-011 ctlIn  input  7  {regWr, memWr, dExtOp, dSizeOp[1:0], jal, mem2reg}.
REQ-012 pc8, aluOut, busBOut  output  32 each  registered values for the memory stage; busBOut carries store data.
REQ-013 RwOut (5), regWrOut, memWr, dExtOp, dSizeOp (2), jal, mem2reg  output  registered pass-through fields.
REQ-014 exStall  output  1  combinational; asks upstream to hold the instruction currently in this stage.

Function
REQ-015 aluCtr encodings; B = selected operand; shift count = busA[4:0]:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR
- 6 SLT (signed); 7 SLTU
- 8 SLL B; 9 SRL B; A SRA B
- B LUI = B<<16
- C MFHI; D MFLO; E MULT; F MULTU
- All arithmetic is 32-bit wraparound; no overflow trap.
REQ-016 Multiplier FSM has two states, IDLE and BUSY, plus a 5-bit counter; it uses an iterative shift-add algorithm at one bit per cycle.
REQ-017 MULT/MULTU accept:
- Conditions: state IDLE, exHold=0, exKill=0, exRst=0.
- Accept edge E0: latch operands, counter=31, state goes to BUSY.
- Signed multiplication operates on magnitudes; the 64-bit result is negated when operand signs differ.
REQ-018 BUSY: the counter decrements each edge; at the edge where counter==0 (E32), {HI,LO} receives the 64-bit product and the state returns to IDLE.
REQ-019 The FSM advances independently of exHold.
REQ-020 exStall=1 iff aluCtr is C/D/E/F and state is BUSY; it is 0 otherwise, including during exRst.
REQ-021 Pipeline register priority: exRst > exKill > exHold > exStall > load.
- exStall=1 (no hold or kill): load a bubble, i.e. all fields zero.
- exHold=1: retain all fields.
REQ-022 Load contents:
- aluOut = ALU result, or HI/LO for MFHI/MFLO.
- All other fields pass through.
- For MULT/MULTU, regWrOut is forced to 0 and aluOut=0.
REQ-023 MFHI/MFLO issued in the first cycle after E32 reads the new product; no forwarding from a partial product.
REQ-024 A MULT issued while BUSY stalls; it is accepted in the first IDLE cycle, and the previous HI/LO is then overwritten at its own E32.
REQ-025 exKill on the acceptance cycle prevents the start; exKill does not abort a multiply that is already BUSY.

Reset
REQ-026 On exRst assertion:
- All outputs are 0 and exStall is 0.
- HI=LO=0, counter=0, state IDLE.
- A multiply in flight is aborted with no HI/LO update.
REQ-027 After exRst deasserts, the first rising edge operates normally.

Verification
REQ-028 ADD busA=0x7FFFFFFF, imm32=1, aluSrc=1 -> aluOut=0x80000000 after one edge; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
REQ-029 MULT 7 x -3, then MFLO/MFHI -> exStall high for 32 cycles; then LO=0xFFFFFFEB, HI=0xFFFFFFFF; MULT bubble has regWrOut=0.
REQ-030 MULTU 0xFFFFFFFF x 2 -> HI=0x00000001, LO=0xFFFFFFFE at E32; MFHI in the cycle after E32 returns 0x1 with no stall.
REQ-031 exHold=1 for 5 cycles during BUSY -> outputs frozen; HI/LO still update at E32; exKill on MULT cycle -> state stays IDLE, HI/LO unchanged.
REQ-032 exRst pulse at BUSY cycle 10 -> outputs zero immediately, state IDLE, HI/LO=0; subsequent MFLO returns 0 with no stall.
REQ-033 Back-to-back MULT 3x4 then MULT 5x6 -> second stalls until IDLE; final LO=30, HI=0.
